// File: rtl/ball_tx_packer.sv
// Packs ball/win state into short I2C register-write packets and streams them
// byte by byte to an I2C master, with NACK retry and failure reporting.
module ball_tx_packer #(
  parameter int          MAX_RETRY   = 3,
  parameter logic [19:0] SLOW_THRESH = 20'd270000
) (
  input  logic              clk_25MHZ,
  input  logic              reset_n,
  input  logic              ball_send_trigger,
  input  logic              win_send_trigger,
  input  logic [9:0]        ball_y,
  input  logic signed [9:0] ball_vy,
  input  logic [1:0]        gravity_counter,
  input  logic [19:0]       ball_speed,
  input  logic              win_flag,
  output logic              tx_req,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  input  logic              tx_done,
  input  logic              tx_nack,
  output logic              is_i2c_master_done,
  output logic              win_sent,
  output logic              tx_fail,
  output logic              busy
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             ball_hist_q, win_hist_q;
  logic             win_pend_q, win_pend_d;
  logic             is_win_q, is_win_d;
  logic [2:0]       idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [7:0][7:0]  buf_q, buf_d;
  logic             tx_fail_q, tx_fail_d;

  logic       ball_edge, win_edge, done_evt;
  logic [2:0] pkt_last;
  logic [7:0] vy_sat;

  assign ball_edge = ball_send_trigger & ~ball_hist_q;
  assign win_edge  = win_send_trigger & ~win_hist_q;
  assign pkt_last  = is_win_q ? 3'd1 : 3'd5;
  assign done_evt  = tx_done && (state_q == S_SEND || state_q == S_WAIT);

  always_comb begin
    if (ball_vy > 10'sd127)       vy_sat = 8'h7F;
    else if (ball_vy < -10'sd128) vy_sat = 8'h80;
    else                          vy_sat = ball_vy[7:0];
  end

  always_comb begin
    state_d    = state_q;
    win_pend_d = win_pend_q;
    is_win_d   = is_win_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    buf_d      = buf_q;
    tx_fail_d  = 1'b0;

    // A win edge is never lost: it waits behind a ball packet or a busy block.
    if (win_edge && (state_q != S_IDLE || ball_edge)) win_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (ball_edge) begin
          state_d  = S_LOAD;
          is_win_d = 1'b0;
        end else if (win_edge || win_pend_q) begin
          state_d    = S_LOAD;
          is_win_d   = 1'b1;
          win_pend_d = 1'b0;
        end
      end
      S_LOAD: begin
        // Retries pass through LOAD for the tx_req gap but keep the original buffer.
        if (retry_q == '0) begin
          buf_d = '0;
          if (is_win_q) begin
            buf_d[0] = 8'h05;
            buf_d[1] = {7'b0, win_flag};
          end else begin
            buf_d[0] = 8'h00;
            buf_d[1] = {ball_y[9:8], 6'b0};
            buf_d[2] = ball_y[7:0];
            buf_d[3] = vy_sat;
            buf_d[4] = {6'b0, gravity_counter};
            buf_d[5] = {7'b0, ball_speed >= SLOW_THRESH};
          end
        end
        idx_d   = 3'd0;
        state_d = S_REQ;
      end
      S_REQ:  state_d = S_SEND;
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == pkt_last) state_d = S_WAIT;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      S_FIN: begin
        retry_d = '0;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (done_evt) begin
      if (!tx_nack) begin
        state_d = S_FIN;
      end else if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        idx_d   = 3'd0;
        state_d = S_LOAD;
      end else begin
        retry_d   = '0;
        tx_fail_d = 1'b1;
        state_d   = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ball_hist_q <= 1'b0;
      win_hist_q  <= 1'b0;
      win_pend_q  <= 1'b0;
      is_win_q    <= 1'b0;
      idx_q       <= 3'd0;
      retry_q     <= '0;
      buf_q       <= '0;
      tx_fail_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_hist_q <= ball_send_trigger;
      win_hist_q  <= win_send_trigger;
      win_pend_q  <= win_pend_d;
      is_win_q    <= is_win_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      buf_q       <= buf_d;
      tx_fail_q   <= tx_fail_d;
    end
  end

  assign tx_req             = (state_q == S_REQ) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign tx_valid           = (state_q == S_SEND);
  assign tx_byte            = tx_valid ? buf_q[idx_q] : 8'h00;
  assign tx_last            = tx_valid && (idx_q == pkt_last);
  assign is_i2c_master_done = (state_q == S_FIN) && !is_win_q;
  assign win_sent           = (state_q == S_FIN) && is_win_q;
  assign tx_fail            = tx_fail_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_ball_tx_packer.sv
// Scoreboard bench for ball_tx_packer: directed packets, stalls, NACK retries, reset abort.
module tb_ball_tx_packer;
  logic              clk_25MHZ = 1'b0;
  logic              reset_n;
  logic              ball_send_trigger, win_send_trigger;
  logic [9:0]        ball_y;
  logic signed [9:0] ball_vy;
  logic [1:0]        gravity_counter;
  logic [19:0]       ball_speed;
  logic              win_flag;
  logic              tx_req, tx_valid, tx_ready, tx_last, tx_done, tx_nack;
  logic [7:0]        tx_byte;
  logic              is_i2c_master_done, win_sent, tx_fail, busy;

  always #20 clk_25MHZ = ~clk_25MHZ;

  ball_tx_packer dut (
    .clk_25MHZ(clk_25MHZ), .reset_n(reset_n),
    .ball_send_trigger(ball_send_trigger), .win_send_trigger(win_send_trigger),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .ball_speed(ball_speed), .win_flag(win_flag),
    .tx_req(tx_req), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .tx_done(tx_done), .tx_nack(tx_nack),
    .is_i2c_master_done(is_i2c_master_done), .win_sent(win_sent),
    .tx_fail(tx_fail), .busy(busy)
  );

  // Event word: {kind, last, byte}; kind 0 byte, 1 ball done, 2 win sent, 3 fail.
  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit nack_all = 1'b0;

  task automatic chk_ev(input logic [10:0] got);
    logic [10:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %h, expected none", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL event: got %h, expected %h", got, e);
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk_25MHZ) begin
    if (reset_n) begin
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        chk_ev({2'd0, tx_last, tx_byte});
      end
      if (is_i2c_master_done) chk_ev({2'd1, 9'd0});
      if (win_sent)           chk_ev({2'd2, 9'd0});
      if (tx_fail)            chk_ev({2'd3, 9'd0});
    end
  end

  // Master model: completes the transaction two clocks after the last byte.
  initial begin
    tx_done = 1'b0;
    tx_nack = 1'b0;
    forever begin
      @(negedge clk_25MHZ);
      if (reset_n && tx_valid && tx_ready && tx_last) begin
        @(posedge clk_25MHZ); #1;
        tx_done = 1'b1;
        tx_nack = nack_all;
        @(posedge clk_25MHZ); #1;
        tx_done = 1'b0;
        tx_nack = 1'b0;
      end
    end
  end

  task automatic push6(input logic [47:0] v);
    for (int i = 0; i < 6; i++) exp_q.push_back({2'd0, (i == 5), v[47-8*i -: 8]});
  endtask

  task automatic push2(input logic [15:0] v);
    exp_q.push_back({3'd0, v[15:8]});
    exp_q.push_back({3'd1, v[7:0]});
  endtask

  task automatic push_ev(input logic [1:0] k);
    exp_q.push_back({k, 9'd0});
  endtask

  task automatic set_data(input logic [9:0] y, input logic signed [9:0] vy,
                          input logic [1:0] g, input logic [19:0] sp);
    ball_y = y; ball_vy = vy; gravity_counter = g; ball_speed = sp;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk_25MHZ);
      n++;
    end
    #1;
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL timeout: %0d events outstanding, busy=%b", exp_q.size(), busy);
    end
  endtask

  task automatic fire_ball();
    @(posedge clk_25MHZ); #1 ball_send_trigger = 1'b1;
    repeat (3) @(posedge clk_25MHZ);
    #1 ball_send_trigger = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_cnt < target && n < 200) begin
      @(negedge clk_25MHZ); #1;
      n++;
    end
    cmp("hs_wait", hs_cnt, target);
  endtask

  initial begin
    int n;
    int base;
    reset_n = 1'b0;
    ball_send_trigger = 1'b0;
    win_send_trigger  = 1'b0;
    win_flag = 1'b0;
    tx_ready = 1'b1;
    set_data(10'd0, 10'sd0, 2'd0, 20'd0);
    repeat (3) begin
      @(negedge clk_25MHZ);
      cmp("reset_outs", {tx_req, tx_valid, tx_last, is_i2c_master_done, win_sent, tx_fail, busy, tx_byte}, 0);
    end
    @(posedge clk_25MHZ); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_25MHZ);

    // Reference packet, latency, trigger held high through the packet
    set_data(10'd620, -10'sd3, 2'd2, 20'd270000);
    push6(48'h00_80_6C_FD_02_01); push_ev(2'd1);
    @(posedge clk_25MHZ); #1 ball_send_trigger = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk_25MHZ); n++;
      @(negedge clk_25MHZ);
      if (tx_valid) break;
    end
    cmp("latency", n, 3);
    wait_idle();
    repeat (10) @(posedge clk_25MHZ);
    cmp("held_trigger_idle", {busy, 8'(exp_q.size())}, 0);
    #1 ball_send_trigger = 1'b0;

    // Saturation and speed threshold
    set_data(10'd5, 10'sd300, 2'd1, 20'd135000);
    push6(48'h00_00_05_7F_01_00); push_ev(2'd1);
    fire_ball(); wait_idle();
    set_data(10'd1023, -10'sd300, 2'd3, 20'd270001);
    push6(48'h00_C0_FF_80_03_01); push_ev(2'd1);
    fire_ball(); wait_idle();
    set_data(10'd256, 10'sd127, 2'd0, 20'd269999);
    push6(48'h00_40_00_7F_00_00); push_ev(2'd1);
    fire_ball(); wait_idle();
    set_data(10'd256, -10'sd128, 2'd0, 20'd269999);
    push6(48'h00_40_00_80_00_00); push_ev(2'd1);
    fire_ball(); wait_idle();

    // Back-pressure on the third byte; input change must not leak into the packet
    set_data(10'h155, -10'sd1, 2'd1, 20'd270000);
    push6(48'h00_40_55_FF_01_01); push_ev(2'd1);
    base = hs_cnt;
    @(posedge clk_25MHZ); #1 ball_send_trigger = 1'b1;
    wait_hs(base + 2);
    @(posedge clk_25MHZ); #1 tx_ready = 1'b0;
    ball_y = 10'h2AA;
    repeat (5) begin
      @(negedge clk_25MHZ);
      cmp("stall_hold", {tx_valid, tx_byte}, {1'b1, 8'h55});
    end
    @(posedge clk_25MHZ); #1 tx_ready = 1'b1;
    wait_idle();
    ball_send_trigger = 1'b0;

    // Simultaneous ball and win edges: ball first, then win
    set_data(10'd2, 10'sd0, 2'd0, 20'd0);
    win_flag = 1'b1;
    push6(48'h00_00_02_00_00_00); push_ev(2'd1);
    push2(16'h05_01); push_ev(2'd2);
    @(posedge clk_25MHZ); #1 ball_send_trigger = 1'b1; win_send_trigger = 1'b1;
    repeat (3) @(posedge clk_25MHZ);
    #1 ball_send_trigger = 1'b0; win_send_trigger = 1'b0;
    wait_idle();

    // Win-only packet
    win_flag = 1'b0;
    push2(16'h05_00); push_ev(2'd2);
    @(posedge clk_25MHZ); #1 win_send_trigger = 1'b1;
    repeat (3) @(posedge clk_25MHZ);
    #1 win_send_trigger = 1'b0;
    wait_idle();

    // NACK on every attempt: original packet plus three retries, then failure
    nack_all = 1'b1;
    set_data(10'd3, 10'sd5, 2'd1, 20'd300000);
    repeat (4) push6(48'h00_00_03_05_01_01);
    push_ev(2'd3);
    fire_ball();
    set_data(10'd999, 10'sd99, 2'd3, 20'd1);
    wait_idle();
    nack_all = 1'b0;

    // Reset during byte 4 with trigger held: abort, then one re-snapshotted packet
    set_data(10'd620, -10'sd3, 2'd2, 20'd270000);
    exp_q.push_back({3'd0, 8'h00});
    exp_q.push_back({3'd0, 8'h80});
    exp_q.push_back({3'd0, 8'h6C});
    base = hs_cnt;
    @(posedge clk_25MHZ); #1 ball_send_trigger = 1'b1;
    wait_hs(base + 3);
    @(posedge clk_25MHZ); #1 reset_n = 1'b0;
    #1 cmp("async_abort", {tx_req, tx_valid, busy}, 0);
    set_data(10'd0, 10'sd200, 2'd1, 20'd0);
    repeat (3) begin
      @(negedge clk_25MHZ);
      cmp("mid_reset_outs", {tx_req, tx_valid, tx_last, is_i2c_master_done, win_sent, tx_fail, busy, tx_byte}, 0);
    end
    push6(48'h00_00_00_7F_01_00); push_ev(2'd1);
    @(posedge clk_25MHZ); #1 reset_n = 1'b1;
    wait_idle();
    repeat (15) @(posedge clk_25MHZ);
    #1 ball_send_trigger = 1'b0;
    cmp("final_queue", {busy, 8'(exp_q.size())}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
